// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the register-file write-back controller slice.
//   WB_DATA_W / WB_ADDR_W : default result and register-address widths
//   wb_req_t              : one write-back request {addr, data}
//   REG_ZERO              : hard-wired zero register; writes to it are dropped
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_writeback_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_writeback_ctrl_if
// Bundles the decode, ALU, load-unit and register-file-write signals of the
// write-back controller.
//   slave  : the controller's view (results in, write port / status out)
//   master : the surrounding pipeline's view
// Signals:
//   IssueEn/IssueAddr        destination reservation from decode
//   CheckAddr1/2, Busy1/2    hazard query from decode
//   AluValid/Addr/Data/Ready ALU result handshake
//   LoadValid/Addr/Data/Ready load result handshake
//   WriteAddress/WriteData/ReadWriteEn register file write port
//   Error                    sticky protocol-violation flag
// -----------------------------------------------------------------------------
interface regfile_writeback_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              IssueEn;
    logic [ADDR_W-1:0] IssueAddr;
    logic [ADDR_W-1:0] CheckAddr1;
    logic [ADDR_W-1:0] CheckAddr2;
    logic              Busy1;
    logic              Busy2;
    logic              AluValid;
    logic [ADDR_W-1:0] AluAddr;
    logic [DATA_W-1:0] AluData;
    logic              AluReady;
    logic              LoadValid;
    logic [ADDR_W-1:0] LoadAddr;
    logic [DATA_W-1:0] LoadData;
    logic              LoadReady;
    logic [ADDR_W-1:0] WriteAddress;
    logic [DATA_W-1:0] WriteData;
    logic              ReadWriteEn;
    logic              Error;

    modport slave (
        input  IssueEn, IssueAddr, CheckAddr1, CheckAddr2,
        input  AluValid, AluAddr, AluData,
        input  LoadValid, LoadAddr, LoadData,
        output Busy1, Busy2, AluReady, LoadReady,
        output WriteAddress, WriteData, ReadWriteEn, Error
    );

    modport master (
        output IssueEn, IssueAddr, CheckAddr1, CheckAddr2,
        output AluValid, AluAddr, AluData,
        output LoadValid, LoadAddr, LoadData,
        input  Busy1, Busy2, AluReady, LoadReady,
        input  WriteAddress, WriteData, ReadWriteEn, Error
    );
endinterface

// File: rtl/wb_load_fifo.sv
// -----------------------------------------------------------------------------
// wb_load_fifo
// Small synchronous FIFO buffering load results until they win the write port.
// Ports:
//   clk, rst   clock / asynchronous active-high reset (pointers and count only)
//   pushEn     write pushData at the rising edge (ignored when full)
//   pushData   entry to enqueue
//   popEn      drop the head entry at the rising edge (ignored when empty)
//   headData   current head entry, valid whenever !empty
//   full/empty occupancy flags
// Push and pop in the same cycle leave the count unchanged.
// -----------------------------------------------------------------------------
module wb_load_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pushEn,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popEn,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] memArray [DEPTH];
    logic [PTR_W-1:0] wrPtrReg;
    logic [PTR_W-1:0] rdPtrReg;
    logic [PTR_W:0]   countReg;
    logic             doPush;
    logic             doPop;

    assign full   = (countReg == (PTR_W + 1)'(DEPTH));
    assign empty  = (countReg == '0);
    assign doPush = pushEn && !full;
    assign doPop  = popEn && !empty;

    // The head must be visible in the same cycle it is arbitrated, so the
    // storage is read asynchronously (a handful of LUT-RAM entries).
    assign headData = memArray[rdPtrReg];

    always_ff @(posedge clk) begin
        if (doPush) begin
            memArray[wrPtrReg] <= pushData;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                countReg <= countReg + (PTR_W + 1)'(1);
            end else if (doPop && !doPush) begin
                countReg <= countReg - (PTR_W + 1)'(1);
            end
        end
    end
endmodule

// File: rtl/regfile_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_writeback_ctrl
// Write-side controller of the register file. Merges ALU results (unbuffered)
// and load results (buffered in wb_load_fifo) onto the single write port, and
// keeps a per-register pending scoreboard for decode hazard checks.
// Ports:
//   clk, rst  clock / asynchronous active-high reset
//   wb        regfile_writeback_ctrl_if.slave (see interface header)
// Arbitration each cycle: a full load FIFO drains first (ALU stalled), else a
// valid ALU result, else the FIFO head. The winner is registered onto
// WriteAddress/WriteData with ReadWriteEn=1 one cycle later; register 0 writes
// are dropped (ReadWriteEn stays 0).
// -----------------------------------------------------------------------------
module regfile_writeback_ctrl
    import wb_pkg::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int LQ_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    regfile_writeback_ctrl_if.slave wb
);
    localparam int REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    // Load FIFO
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic                     fifoPop;
    logic                     loadPush;
    logic [ADDR_W+DATA_W-1:0] fifoHead;
    logic [ADDR_W-1:0]        headAddr;
    logic [DATA_W-1:0]        headData;

    // Arbiter result
    logic                     selValid;
    logic [ADDR_W-1:0]        selAddr;
    logic [DATA_W-1:0]        selData;
    logic                     aluAccept;

    // Output stage
    logic                     writeEnReg;
    logic [ADDR_W-1:0]        writeAddrReg;
    logic [DATA_W-1:0]        writeDataReg;

    // Scoreboard / error
    logic [REGS-1:0]          pendingReg;
    logic [REGS-1:0]          pendingNext;
    logic                     errorReg;
    logic                     errorNext;
    logic                     issueConflict;
    logic                     aluConflict;
    logic                     loadConflict;

    assign {headAddr, headData} = fifoHead;

    // Both sources stall only while the FIFO is full.
    assign wb.LoadReady = !fifoFull;
    assign wb.AluReady  = !fifoFull;
    assign loadPush     = wb.LoadValid && !fifoFull;
    assign aluAccept    = wb.AluValid && !fifoFull;

    wb_load_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (LQ_DEPTH)
    ) u_load_fifo (
        .clk      (clk),
        .rst      (rst),
        .pushEn   (loadPush),
        .pushData ({wb.LoadAddr, wb.LoadData}),
        .popEn    (fifoPop),
        .headData (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    // A load pushed this cycle is not eligible until the next one: the
    // arbiter only sees FIFO contents as of the start of the cycle.
    always_comb begin
        selValid = 1'b0;
        selAddr  = wb.AluAddr;
        selData  = wb.AluData;
        fifoPop  = 1'b0;
        if (fifoFull) begin
            selValid = 1'b1;
            fifoPop  = 1'b1;
            selAddr  = headAddr;
            selData  = headData;
        end else if (wb.AluValid) begin
            selValid = 1'b1;
        end else if (!fifoEmpty) begin
            selValid = 1'b1;
            fifoPop  = 1'b1;
            selAddr  = headAddr;
            selData  = headData;
        end
    end

    // Address/data hold their last values while nothing is selected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeEnReg   <= 1'b0;
            writeAddrReg <= '0;
            writeDataReg <= '0;
        end else begin
            writeEnReg <= selValid && (selAddr != ZERO_ADDR);
            if (selValid) begin
                writeAddrReg <= selAddr;
                writeDataReg <= selData;
            end
        end
    end

    assign wb.ReadWriteEn  = writeEnReg;
    assign wb.WriteAddress = writeAddrReg;
    assign wb.WriteData    = writeDataReg;

    // Pending bit per register. A reservation in the same cycle as the
    // retiring write to that register keeps the bit set (new producer).
    // Register 0 never becomes pending.
    generate
        for (genvar gi = 0; gi < REGS; gi++) begin : g_scoreboard
            if (gi == 0) begin : g_zero
                assign pendingNext[gi] = 1'b0;
            end else begin : g_reg
                logic setHit;
                logic clrHit;
                assign setHit = wb.IssueEn && (wb.IssueAddr == ADDR_W'(gi));
                assign clrHit = writeEnReg && (writeAddrReg == ADDR_W'(gi));
                assign pendingNext[gi] = setHit || (pendingReg[gi] && !clrHit);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendingReg <= '0;
        end else begin
            pendingReg <= pendingNext;
        end
    end

    // Busy drops on the same edge that makes the new value readable.
    assign wb.Busy1 = pendingReg[wb.CheckAddr1];
    assign wb.Busy2 = pendingReg[wb.CheckAddr2];

    // Violations are flagged when a result is accepted by its handshake
    // (ALU into the write stage, load into the FIFO); the write still happens.
    assign issueConflict = wb.IssueEn && (wb.IssueAddr != ZERO_ADDR) && pendingReg[wb.IssueAddr];
    assign aluConflict   = aluAccept && (wb.AluAddr != ZERO_ADDR) && !pendingReg[wb.AluAddr];
    assign loadConflict  = loadPush && (wb.LoadAddr != ZERO_ADDR) && !pendingReg[wb.LoadAddr];
    assign errorNext     = errorReg || issueConflict || aluConflict || loadConflict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errorReg <= 1'b0;
        end else begin
            errorReg <= errorNext;
        end
    end

    assign wb.Error = errorReg;
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
module tb_regfile_writeback_ctrl;
    import wb_pkg::*;

    localparam int LQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regfile_writeback_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_writeback_ctrl #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .LQ_DEPTH (LQ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    // Reference model: load queue, pending set, sticky error, visible write.
    wb_req_t     mq[$];
    bit [31:0]   mPend;
    bit          mErr;
    bit          mWen;
    logic [4:0]  mAddr;
    logic [31:0] mData;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mPend = '0;
        mErr  = 1'b0;
        mWen  = 1'b0;
        mAddr = '0;
        mData = '0;
    endtask

    task automatic drive_idle();
        bus.IssueEn    = 1'b0;
        bus.IssueAddr  = '0;
        bus.CheckAddr1 = '0;
        bus.CheckAddr2 = '0;
        bus.AluValid   = 1'b0;
        bus.AluAddr    = '0;
        bus.AluData    = '0;
        bus.LoadValid  = 1'b0;
        bus.LoadAddr   = '0;
        bus.LoadData   = '0;
    endtask

    // One clock cycle: drive, check DUT against model, advance model, clock.
    task automatic cycle(input bit iss, input logic [4:0] issA,
                         input logic [4:0] c1, input logic [4:0] c2,
                         input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit lv, input logic [4:0] la, input logic [31:0] ld,
                         output bit aluAcc, output bit ldAcc);
        bit      full;
        bit      sel;
        wb_req_t r;
        bus.IssueEn    = iss;
        bus.IssueAddr  = issA;
        bus.CheckAddr1 = c1;
        bus.CheckAddr2 = c2;
        bus.AluValid   = av;
        bus.AluAddr    = aa;
        bus.AluData    = ad;
        bus.LoadValid  = lv;
        bus.LoadAddr   = la;
        bus.LoadData   = ld;
        #1;
        full = (mq.size() == LQ);
        chk("AluReady", bus.AluReady, !full);
        chk("LoadReady", bus.LoadReady, !full);
        chk("Busy1", bus.Busy1, mPend[c1]);
        chk("Busy2", bus.Busy2, mPend[c2]);
        chk("ReadWriteEn", bus.ReadWriteEn, mWen);
        if (mWen) begin
            chk("WriteAddress", bus.WriteAddress, mAddr);
            chk("WriteData", bus.WriteData, mData);
            $display("t=%0t write x%0d = %08h", $time, bus.WriteAddress, bus.WriteData);
        end
        chk("Error", bus.Error, mErr);

        aluAcc = av && !full;
        ldAcc  = lv && !full;
        sel    = 1'b0;
        r      = '0;
        if (full) begin
            r = mq.pop_front();
            sel = 1'b1;
        end else if (av) begin
            r.addr = aa;
            r.data = ad;
            sel = 1'b1;
        end else if (mq.size() != 0) begin
            r = mq.pop_front();
            sel = 1'b1;
        end
        if (iss && issA != 0 && mPend[issA]) mErr = 1'b1;
        if (aluAcc && aa != 0 && !mPend[aa]) mErr = 1'b1;
        if (ldAcc && la != 0 && !mPend[la]) mErr = 1'b1;
        if (ldAcc) begin
            wb_req_t p;
            p.addr = la;
            p.data = ld;
            mq.push_back(p);
        end
        if (mWen) mPend[mAddr] = 1'b0;
        if (iss && issA != 0) mPend[issA] = 1'b1;
        if (sel) begin
            mAddr = r.addr;
            mData = r.data;
            mWen  = (r.addr != 0);
        end else begin
            mWen = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
        bit a, l;
        cycle(0, 0, c1, c2, 0, 0, 0, 0, 0, 0, a, l);
    endtask

    task automatic issue(input logic [4:0] r);
        bit a, l;
        cycle(1, r, r, 0, 0, 0, 0, 0, 0, 0, a, l);
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        #2;
        chk("rst_ReadWriteEn", bus.ReadWriteEn, 1'b0);
        chk("rst_LoadReady", bus.LoadReady, 1'b1);
        chk("rst_Error", bus.Error, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit aA, lA;
        int ai, li;
        bit rav, rlv;
        logic [4:0]  raa, rla;
        logic [31:0] rad, rld;

        drive_idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_WriteAddress", bus.WriteAddress, 5'd0);
        chk("reset_WriteData", bus.WriteData, 32'd0);
        rst = 1'b0;
        idle(5'd1, 5'd31);

        // 1: reserve x5, ALU writes it; Busy tracks until readable.
        issue(5'd5);
        cycle(0, 0, 5'd5, 5'd0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, aA, lA);
        idle(5'd5, 5'd5);
        idle(5'd5, 5'd5);
        chk("t1_busy5_cleared", bus.Busy1, 1'b0);

        // 2: ALU and load in the same cycle; ALU first, load next.
        issue(5'd3);
        issue(5'd4);
        cycle(0, 0, 5'd3, 5'd4, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2, aA, lA);
        idle(5'd3, 5'd4);
        idle(5'd3, 5'd4);
        idle(5'd3, 5'd4);

        // 3: continuous ALU traffic while 5 loads arrive; FIFO fills and drains first.
        for (int i = 0; i < 5; i++) issue(5'(10 + i));
        for (int i = 0; i < 8; i++) issue(5'(16 + i));
        ai = 0;
        li = 0;
        for (int k = 0; k < 40 && (ai < 8 || li < 5); k++) begin
            cycle(0, 0, 5'(10 + li % 5), 5'(16 + ai % 8),
                  ai < 8, 5'(16 + ai), 32'hA000_0000 + 32'(ai),
                  li < 5, 5'(10 + li), 32'hB000_0000 + 32'(li), aA, lA);
            if (aA) ai++;
            if (lA) li++;
        end
        repeat (6) idle(5'd10, 5'd14);

        // 4: writes to x0 are dropped, x0 never busy.
        issue(5'd0);
        cycle(0, 0, 5'd0, 5'd0, 1, 5'd0, 32'h1234_5678, 0, 0, 0, aA, lA);
        idle(5'd0, 5'd0);
        chk("t4_x0_no_write", bus.ReadWriteEn, 1'b0);
        idle(5'd0, 5'd0);

        // 5: double reservation is a sticky error; the write still retires.
        issue(5'd7);
        issue(5'd7);
        cycle(0, 0, 5'd7, 5'd0, 1, 5'd7, 32'h0000_0777, 0, 0, 0, aA, lA);
        idle(5'd7, 5'd7);
        idle(5'd7, 5'd7);
        chk("t5_error_sticky", bus.Error, 1'b1);
        chk("t5_busy7_cleared", bus.Busy1, 1'b0);

        // 6: reset with two loads queued and an ALU write staged.
        issue(5'd8);
        cycle(0, 0, 5'd8, 5'd0, 1, 5'd21, 32'h11, 1, 5'd22, 32'h22, aA, lA);
        cycle(0, 0, 5'd8, 5'd0, 1, 5'd23, 32'h33, 1, 5'd24, 32'h44, aA, lA);
        bus.AluValid = 1'b1;
        bus.AluAddr  = 5'd25;
        bus.AluData  = 32'h55;
        bus.CheckAddr1 = 5'd8;
        #1;
        do_reset();
        idle(5'd8, 5'd22);
        idle(5'd24, 5'd25);
        idle(5'd8, 5'd0);

        // Randomized traffic; sources hold their request until accepted.
        for (int round = 0; round < 3; round++) begin
            rav = 1'b0;
            rlv = 1'b0;
            raa = '0; rla = '0; rad = '0; rld = '0;
            for (int k = 0; k < 150; k++) begin
                if (!rav && $urandom_range(0, 1) == 1) begin
                    rav = 1'b1;
                    raa = 5'($urandom_range(0, 7));
                    rad = $urandom;
                end
                if (!rlv && $urandom_range(0, 9) < 6) begin
                    rlv = 1'b1;
                    rla = 5'($urandom_range(0, 7));
                    rld = $urandom;
                end
                cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      rav, raa, rad, rlv, rla, rld, aA, lA);
                if (aA) rav = 1'b0;
                if (lA) rlv = 1'b0;
            end
            do_reset();
            idle(5'd1, 5'd2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
